interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/csr_pkg.sv | 24 ++
 rtl/irq_priority_encoder.sv | 27 ++
 rtl/interrupt_controller.sv | 137 +++++++++++++
 tb/tb_interrupt_controller.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg -- shared types and constants for the machine-mode trap path.
//   state_e             : interrupt controller FSM states
//   CAUSE_ILLEGAL_INSTR : mcause value for an illegal-instruction exception
//   CAUSE_IRQ_BASE      : mcause value for external line 0 (line n adds n)
//   irq_cause()         : builds the interrupt mcause from a line index
package csr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_HANDLER_IRQ = 2'd1,
    ST_HANDLER_EXC = 2'd2
  } state_e;

  localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'h0000_0002;
  localparam logic [31:0] CAUSE_IRQ_BASE      = 32'h8000_0010;

  // Up to 16 lines, so a 4-bit index always suffices.
  localparam int IRQ_IDX_W = 4;

  function automatic logic [31:0] irq_cause(input logic [IRQ_IDX_W-1:0] idx);
    return CAUSE_IRQ_BASE + {{(32-IRQ_IDX_W){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder -- combinational lowest-index-wins selector.
//   i_req   : N_IRQ request bits (already masked by the caller)
//   o_idx   : index of the lowest set request bit (0 when none)
//   o_valid : at least one request bit is set
module irq_priority_encoder
  import csr_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic [N_IRQ-1:0]     i_req,
  output logic [IRQ_IDX_W-1:0] o_idx,
  output logic                 o_valid
);

  // Scan from the top down so the last hit, the lowest index, sticks.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IRQ_IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// interrupt_controller -- edge-triggered external interrupts plus the
// illegal-instruction exception, single-level with one exception nesting
// level on top of an interrupt handler.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   irq_req_i   : external interrupt lines (rising-edge sensitive)
//   mie_i       : CSR mie, bit 16+n enables line n
//   exception_i : illegal-instruction exception this cycle
//   mret_i      : mret executed this cycle
//   trap_o      : trap entry this cycle (combinational)
//   mcause_o    : cause code, zero whenever trap_o is low
//   irq_ret_o   : one-cycle one-hot acknowledge of the serviced line
module interrupt_controller
  import csr_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             exception_i,
  input  logic             mret_i,
  output logic             trap_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [N_IRQ-1:0]       r_sampled;
  logic [N_IRQ-1:0]       r_pending;
  logic [IRQ_IDX_W-1:0]   r_irq_id;
  logic                   r_irq_active;

  logic [N_IRQ-1:0]       w_rise;
  logic [N_IRQ-1:0]       w_eligible;
  logic [IRQ_IDX_W-1:0]   w_sel_idx;
  logic                   w_sel_valid;
  logic                   w_take_irq;
  logic                   w_irq_ret_fire;
  logic                   w_unused_mie;

  // Only the line-enable field of mie is consulted; the rest is folded
  // away so partial use of the CSR stays intentional.
  assign w_unused_mie = ^mie_i;

  assign w_rise     = irq_req_i & ~r_sampled;
  // Pending bits ignore the mask; masking only gates selection.
  assign w_eligible = r_pending & mie_i[16 +: N_IRQ];

  irq_priority_encoder #(
    .N_IRQ (N_IRQ)
  ) u_prio (
    .i_req   (w_eligible),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_valid)
  );

  // An exception always beats a pending interrupt, and interrupts are only
  // taken from IDLE (no nesting).
  assign w_take_irq = !rst_i && (r_state == ST_IDLE) && !exception_i && w_sel_valid;

  // Exception has precedence over mret in the same cycle.
  assign w_irq_ret_fire = !rst_i && (r_state == ST_HANDLER_IRQ) && mret_i && !exception_i;

  // ---------------- state register ----------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (exception_i)      w_state_nxt = ST_HANDLER_EXC;
        else if (w_sel_valid) w_state_nxt = ST_HANDLER_IRQ;
      end
      ST_HANDLER_IRQ: begin
        if (exception_i) w_state_nxt = ST_HANDLER_EXC;
        else if (mret_i) w_state_nxt = ST_IDLE;
      end
      ST_HANDLER_EXC: begin
        // Returning from an exception resumes the interrupted IRQ handler
        // if one was running underneath.
        if (exception_i) w_state_nxt = ST_HANDLER_EXC;
        else if (mret_i) w_state_nxt = r_irq_active ? ST_HANDLER_IRQ : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  always_comb begin
    trap_o   = 1'b0;
    mcause_o = '0;
    if (!rst_i) begin
      if (exception_i) begin
        trap_o   = 1'b1;
        mcause_o = CAUSE_ILLEGAL_INSTR;
      end else if (r_state == ST_IDLE && w_sel_valid) begin
        trap_o   = 1'b1;
        mcause_o = irq_cause(w_sel_idx);
      end
    end
  end

  for (genvar n = 0; n < N_IRQ; n++) begin : g_ret
    assign irq_ret_o[n] = w_irq_ret_fire && (r_irq_id == IRQ_IDX_W'(n));
  end

  // ---------------- line sampling, pending and active-IRQ bookkeeping ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sampled    <= '0;
      r_pending    <= '0;
      r_irq_id     <= '0;
      r_irq_active <= 1'b0;
    end else begin
      r_sampled <= irq_req_i;
      // A fresh edge in the same cycle as the acknowledge keeps the bit set.
      r_pending <= (r_pending & ~irq_ret_o) | w_rise;
      if (w_take_irq) begin
        r_irq_id     <= w_sel_idx;
        r_irq_active <= 1'b1;
      end else if (w_irq_ret_fire) begin
        r_irq_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller -- directed vectors with hand-computed results.
// Inputs change 2 time units after the rising edge; outputs are checked
// 1 unit later, well away from either clock edge.
module tb_interrupt_controller;

  localparam int N = 16;

  logic          clk;
  logic          rst;
  logic [N-1:0]  irq;
  logic [31:0]   mie;
  logic          exc;
  logic          mret;
  logic          trap;
  logic [31:0]   mcause;
  logic [N-1:0]  ret;

  int n_cmp = 0;
  int n_bad = 0;

  interrupt_controller #(.N_IRQ(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .irq_req_i   (irq),
    .mie_i       (mie),
    .exception_i (exc),
    .mret_i      (mret),
    .trap_o      (trap),
    .mcause_o    (mcause),
    .irq_ret_o   (ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Check all three outputs against expectations.
  task automatic chk_out(input string tag, input logic t, input logic [31:0] c, input logic [N-1:0] r);
    #1;
    chk({tag, ".trap"},   32'(t), 32'(trap));
    chk({tag, ".mcause"}, mcause, c);
    chk({tag, ".ret"},    32'(ret), 32'(r));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; irq = 16'hFFFF; mie = 32'h0; exc = 1'b0; mret = 1'b0;

    // ---- reset: all lines high, outputs must stay low ----
    cyc();
    chk_out("rst0", 1'b0, 32'h0, 16'h0);
    cyc();
    chk_out("rst1", 1'b0, 32'h0, 16'h0);
    exc = 1'b1;
    chk_out("rst_exc", 1'b0, 32'h0, 16'h0);
    exc = 1'b0;
    irq = 16'h0;
    cyc();
    rst = 1'b0; mie = 32'hFFFF_0000;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk_out("post_rst_nopend", 1'b0, 32'h0, 16'h0);
    end

    // ---- single interrupt on line 0 ----
    mie = 32'h0001_0000; irq = 16'h0001;
    chk_out("single_pre", 1'b0, 32'h0, 16'h0);
    cyc();
    chk_out("single_trap", 1'b1, 32'h8000_0010, 16'h0);
    cyc();
    chk_out("single_inhdl", 1'b0, 32'h0, 16'h0);
    irq = 16'h0; mret = 1'b1;
    chk_out("single_ret", 1'b0, 32'h0, 16'h0001);
    cyc();
    mret = 1'b0;
    chk_out("single_idle", 1'b0, 32'h0, 16'h0);
    cyc();
    chk_out("single_idle2", 1'b0, 32'h0, 16'h0);

    // ---- priority: lines 3 and 5 together ----
    mie = 32'h0028_0000; irq = 16'h0028;
    cyc();
    chk_out("prio_first", 1'b1, 32'h8000_0013, 16'h0);
    cyc();
    chk_out("prio_inhdl", 1'b0, 32'h0, 16'h0);
    mret = 1'b1;
    chk_out("prio_ret3", 1'b0, 32'h0, 16'h0008);
    cyc();
    mret = 1'b0;
    chk_out("prio_second", 1'b1, 32'h8000_0015, 16'h0);
    cyc();
    mret = 1'b1;
    chk_out("prio_ret5", 1'b0, 32'h0, 16'h0020);
    cyc();
    mret = 1'b0; irq = 16'h0;
    chk_out("prio_idle", 1'b0, 32'h0, 16'h0);

    // ---- masking: line 2 pending while disabled ----
    mie = 32'h0; irq = 16'h0004;
    cyc();
    chk_out("mask_blocked", 1'b0, 32'h0, 16'h0);
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk_out("mask_wait", 1'b0, 32'h0, 16'h0);
    end
    mie = 32'h0004_0000;
    chk_out("mask_enable", 1'b1, 32'h8000_0012, 16'h0);
    cyc();
    mret = 1'b1;
    chk_out("mask_ret", 1'b0, 32'h0, 16'h0004);
    cyc();
    mret = 1'b0; irq = 16'h0; mie = 32'h0;
    cyc();

    // ---- exception inside IRQ handler for line 4 ----
    mie = 32'h0010_0000; irq = 16'h0010;
    cyc();
    chk_out("nest_irq", 1'b1, 32'h8000_0014, 16'h0);
    cyc();
    exc = 1'b1;
    chk_out("nest_exc", 1'b1, 32'h0000_0002, 16'h0);
    cyc();
    exc = 1'b0;
    chk_out("nest_inexc", 1'b0, 32'h0, 16'h0);
    mret = 1'b1;
    chk_out("nest_mret1", 1'b0, 32'h0, 16'h0);
    cyc();
    mret = 1'b0;
    chk_out("nest_backirq", 1'b0, 32'h0, 16'h0);
    // exception and mret together: exception wins, no acknowledge
    exc = 1'b1; mret = 1'b1;
    chk_out("nest_excmret", 1'b1, 32'h0000_0002, 16'h0);
    cyc();
    exc = 1'b0;
    chk_out("nest_mret2", 1'b0, 32'h0, 16'h0);
    cyc();
    chk_out("nest_mret3", 1'b0, 32'h0, 16'h0010);
    cyc();
    mret = 1'b0; irq = 16'h0;
    chk_out("nest_idle", 1'b0, 32'h0, 16'h0);

    // ---- exception while line 1 is eligible in IDLE ----
    mie = 32'h0002_0000; irq = 16'h0002;
    cyc();
    exc = 1'b1;
    chk_out("simul_exc", 1'b1, 32'h0000_0002, 16'h0);
    cyc();
    exc = 1'b0; mret = 1'b1;
    chk_out("simul_mret", 1'b0, 32'h0, 16'h0);
    cyc();
    mret = 1'b0;
    chk_out("simul_irq", 1'b1, 32'h8000_0011, 16'h0);
    cyc();
    mret = 1'b1;
    chk_out("simul_ret", 1'b0, 32'h0, 16'h0002);
    cyc();
    // mret in IDLE is ignored
    chk_out("idle_mret", 1'b0, 32'h0, 16'h0);
    cyc();
    mret = 1'b0; irq = 16'h0;
    cyc();

    // ---- re-edge during own handler, coincident with mret: set wins ----
    mie = 32'h0001_0000; irq = 16'h0001;
    cyc();
    chk_out("reedge_trap", 1'b1, 32'h8000_0010, 16'h0);
    cyc();
    irq = 16'h0;
    cyc();
    irq = 16'h0001; mret = 1'b1;
    chk_out("reedge_ret", 1'b0, 32'h0, 16'h0001);
    cyc();
    mret = 1'b0;
    chk_out("reedge_again", 1'b1, 32'h8000_0010, 16'h0);
    cyc();

    // ---- reset mid-handler: no acknowledge, nothing left pending ----
    rst = 1'b1; mret = 1'b1;
    chk_out("rst_mid", 1'b0, 32'h0, 16'h0);
    cyc();
    rst = 1'b0; mret = 1'b0; irq = 16'h0;
    cyc();
    chk_out("rst_mid_after", 1'b0, 32'h0, 16'h0);
    cyc();
    chk_out("rst_mid_after2", 1'b0, 32'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
